// File: rtl/misao_fetch_if.sv
// rtl/misao_fetch_if.sv - memory, decoder and redirect signals of the nibble prefetch unit
interface misao_fetch_if #(
  parameter int ADDR_W = 15
);
  logic              mem_enable_read;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data_in;
  logic              mem_busy;
  logic              nib_valid;
  logic [3:0]        nib_data;
  logic [ADDR_W:0]   nib_pc;
  logic              nib_ready;
  logic              redirect;
  logic [ADDR_W:0]   redirect_pc;

  modport master (
    output mem_enable_read, mem_addr, nib_valid, nib_data, nib_pc,
    input  mem_data_in, mem_busy, nib_ready, redirect, redirect_pc
  );

  modport slave (
    input  mem_enable_read, mem_addr, nib_valid, nib_data, nib_pc,
    output mem_data_in, mem_busy, nib_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/misao_fetch.sv
// rtl/misao_fetch.sv - byte-to-nibble prefetch queue feeding the MISA-O decoder
// Sequential byte reads, low nibble first, flushed and restarted on redirect.
module misao_fetch #(
  parameter int ADDR_W    = 15,
  parameter int NIB_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  misao_fetch_if.master bus
);
  localparam int CNT_W = $clog2(NIB_DEPTH + 1);
  localparam int IDX_W = $clog2(NIB_DEPTH);
  localparam int PC_W  = ADDR_W + 1;

  logic [ADDR_W-1:0] fetch_addr;
  logic [ADDR_W-1:0] resp_addr;
  logic              drop_low;
  logic              inflight;
  logic [CNT_W-1:0]  count;
  logic [3:0]        q_data [NIB_DEPTH];
  logic [PC_W-1:0]   q_pc   [NIB_DEPTH];

  logic [3:0]        n_data [NIB_DEPTH];
  logic [PC_W-1:0]   n_pc   [NIB_DEPTH];
  logic [CNT_W-1:0]  n_count;
  logic [CNT_W-1:0]  base;
  logic              fits;
  logic              issue;
  logic              pop;

  // Room must cover what is queued, the byte already on its way, and the new byte.
  assign fits  = (int'(count) + (inflight ? 2 : 0) + 2) <= NIB_DEPTH;
  assign issue = rst && !bus.redirect && !bus.mem_busy && fits;
  assign pop   = (count != '0) && bus.nib_ready;

  assign bus.mem_enable_read = issue;
  assign bus.mem_addr        = fetch_addr;
  assign bus.nib_valid       = (count != '0);
  assign bus.nib_data        = q_data[0];
  assign bus.nib_pc          = q_pc[0];

  // Entry 0 is always the head, so the decoder-facing outputs come straight from flops.
  always_comb begin
    for (int i = 0; i < NIB_DEPTH; i++) begin
      n_data[i] = q_data[i];
      n_pc[i]   = q_pc[i];
    end
    if (pop) begin
      for (int i = 0; i < NIB_DEPTH - 1; i++) begin
        n_data[i] = q_data[i+1];
        n_pc[i]   = q_pc[i+1];
      end
    end
    base    = count - {{(CNT_W-1){1'b0}}, pop};
    n_count = base;
    if (inflight) begin
      if (drop_low) begin
        n_data[IDX_W'(base)] = bus.mem_data_in[7:4];
        n_pc[IDX_W'(base)]   = {resp_addr, 1'b1};
        n_count              = base + CNT_W'(1);
      end else begin
        n_data[IDX_W'(base)]          = bus.mem_data_in[3:0];
        n_pc[IDX_W'(base)]            = {resp_addr, 1'b0};
        n_data[IDX_W'(base + CNT_W'(1))] = bus.mem_data_in[7:4];
        n_pc[IDX_W'(base + CNT_W'(1))]   = {resp_addr, 1'b1};
        n_count                       = base + CNT_W'(2);
      end
    end
  end

  // With fixed one-cycle latency a stale byte always lands in the redirect cycle
  // itself, where the flush discards it; nothing stale survives past that edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_addr <= '0;
      resp_addr  <= '0;
      drop_low   <= 1'b0;
      inflight   <= 1'b0;
      count      <= '0;
      for (int i = 0; i < NIB_DEPTH; i++) begin
        q_data[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NIB_DEPTH; i++) begin
        q_data[i] <= n_data[i];
        q_pc[i]   <= n_pc[i];
      end
      if (bus.redirect) begin
        count      <= '0;
        fetch_addr <= bus.redirect_pc[ADDR_W:1];
        drop_low   <= bus.redirect_pc[0];
        inflight   <= 1'b0;
      end else begin
        count    <= n_count;
        inflight <= issue;
        if (issue) begin
          fetch_addr <= fetch_addr + 1'b1;
          resp_addr  <= fetch_addr;
        end
        if (inflight && drop_low) begin
          drop_low <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_misao_fetch.sv
// tb/tb_misao_fetch.sv - directed and randomized checks of misao_fetch against a nibble-stream model
module tb_misao_fetch;
  localparam int ADDR_W = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  misao_fetch_if #(.ADDR_W(ADDR_W)) bus();
  misao_fetch #(.ADDR_W(ADDR_W), .NIB_DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [7:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) if (bus.mem_enable_read) bus.mem_data_in <= mem[bus.mem_addr];

  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [15:0] model_pc = '0;
  logic        last_req;
  logic [14:0] last_addr;
  logic [3:0]  got_d  [$];
  logic [15:0] got_pc [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // The model is simply a program counter walking nibbles through memory.
  task automatic tick();
    logic [7:0] b;
    logic [3:0] e;
    #1;
    last_req  = bus.mem_enable_read;
    last_addr = bus.mem_addr;
    if (bus.mem_busy || bus.redirect || !rst) check("blocked_no_req", {31'd0, bus.mem_enable_read}, 32'd0);
    if (rst && bus.nib_valid && bus.nib_ready && !bus.redirect) begin
      b = mem[model_pc[15:1]];
      e = model_pc[0] ? b[7:4] : b[3:0];
      check("stream_data", {28'd0, bus.nib_data}, {28'd0, e});
      check("stream_pc", {16'd0, bus.nib_pc}, {16'd0, model_pc});
      got_d.push_back(bus.nib_data);
      got_pc.push_back(bus.nib_pc);
      model_pc = model_pc + 16'd1;
    end
    if (bus.redirect) model_pc = bus.redirect_pc;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic enter_reset();
    rst = 1'b0;
    bus.redirect = 1'b0;
    bus.mem_busy = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic release_reset();
    rst = 1'b1;
    model_pc = '0;
    cyc = 0;
    got_d.delete();
    got_pc.delete();
  endtask

  initial begin
    int first_valid;
    int bubbles;
    int n_req;
    logic [14:0] req_addr [$];
    logic [14:0] issued;
    bit found;

    bus.nib_ready = 1'b0;
    bus.mem_busy = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus.mem_data_in = '0;
    for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = 8'($urandom);
    mem[0] = 8'h14; mem[1] = 8'h3E; mem[5] = 8'hA7; mem[15'h7FFF] = 8'h21;

    // Reset state
    @(negedge clk); @(negedge clk);
    #1;
    check("rst_nib_valid", {31'd0, bus.nib_valid}, 0);
    check("rst_nib_data", {28'd0, bus.nib_data}, 0);
    check("rst_nib_pc", {16'd0, bus.nib_pc}, 0);
    check("rst_mem_en", {31'd0, bus.mem_enable_read}, 0);
    check("rst_mem_addr", {17'd0, bus.mem_addr}, 0);
    @(negedge clk);

    // Stream from reset
    bus.nib_ready = 1'b1;
    release_reset();
    #1;
    check("c0_req", {31'd0, bus.mem_enable_read}, 1);
    check("c0_addr", {17'd0, bus.mem_addr}, 0);
    first_valid = -1;
    bubbles = 0;
    for (int i = 0; i < 16; i++) begin
      if (bus.nib_valid && first_valid < 0) first_valid = cyc;
      if (cyc >= 2 && !bus.nib_valid) bubbles++;
      tick();
    end
    check("first_valid_cyc", first_valid, 2);
    check("stream_bubbles", bubbles, 0);
    check("s_d0", {28'd0, got_d[0]}, 32'h4);
    check("s_d1", {28'd0, got_d[1]}, 32'h1);
    check("s_d2", {28'd0, got_d[2]}, 32'hE);
    check("s_d3", {28'd0, got_d[3]}, 32'h3);
    check("s_pc3", {16'd0, got_pc[3]}, 32'h3);

    // Backpressure
    enter_reset();
    bus.nib_ready = 1'b0;
    release_reset();
    n_req = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (last_req) begin n_req++; req_addr.push_back(last_addr); end
    end
    check("bp_reads", n_req, 2);
    check("bp_addr0", {17'd0, req_addr[0]}, 0);
    check("bp_addr1", {17'd0, req_addr[1]}, 1);
    check("bp_valid", {31'd0, bus.nib_valid}, 1);
    bus.nib_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    check("bp_d0", {28'd0, got_d[0]}, 32'h4);
    check("bp_d1", {28'd0, got_d[1]}, 32'h1);
    check("bp_d2", {28'd0, got_d[2]}, 32'hE);
    check("bp_d3", {28'd0, got_d[3]}, 32'h3);
    check("bp_pc4", {16'd0, got_pc[4]}, 32'h4);

    // Odd redirect while byte 2 is in flight
    enter_reset();
    release_reset();
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (last_req && last_addr == 15'd2) found = 1;
    end
    check("redir_found_byte2", {31'd0, found}, 1);
    bus.redirect = 1'b1;
    bus.redirect_pc = 16'h000B;
    #1;
    check("redir_noreq", {31'd0, bus.mem_enable_read}, 0);
    tick();
    got_d.delete(); got_pc.delete();
    bus.redirect = 1'b0;
    #1;
    check("redir_r1_req", {31'd0, bus.mem_enable_read}, 1);
    check("redir_r1_addr", {17'd0, bus.mem_addr}, 5);
    check("redir_r1_valid", {31'd0, bus.nib_valid}, 0);
    tick();
    check("redir_r2_valid", {31'd0, bus.nib_valid}, 0);
    tick();
    check("redir_r3_valid", {31'd0, bus.nib_valid}, 1);
    check("redir_r3_data", {28'd0, bus.nib_data}, 32'hA);
    check("redir_r3_pc", {16'd0, bus.nib_pc}, 32'h0B);
    for (int i = 0; i < 4; i++) tick();
    check("redir_first_pc", {16'd0, got_pc[0]}, 32'h0B);

    // mem_busy mid-stream
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (last_req) begin found = 1; issued = last_addr; end
    end
    check("busy_found_req", {31'd0, found}, 1);
    got_pc.delete(); got_d.delete();
    bus.mem_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("busy_no_req", {31'd0, bus.mem_enable_read}, 0);
      tick();
    end
    bus.mem_busy = 1'b0;
    #1;
    check("busy_resume_req", {31'd0, bus.mem_enable_read}, 1);
    check("busy_resume_addr", {17'd0, bus.mem_addr}, {17'd0, issued + 15'd1});
    found = 0;
    foreach (got_pc[i]) if (got_pc[i] == {issued, 1'b1}) found = 1;
    check("busy_inflight_delivered", {31'd0, found}, 1);

    // Address wrap
    enter_reset();
    mem[0] = 8'h43;
    release_reset();
    bus.redirect = 1'b1;
    bus.redirect_pc = 16'hFFFE;
    tick();
    bus.redirect = 1'b0;
    req_addr.delete();
    for (int i = 0; i < 10; i++) begin
      tick();
      if (last_req) req_addr.push_back(last_addr);
    end
    check("wrap_addr0", {17'd0, req_addr[0]}, 32'h7FFF);
    check("wrap_addr1", {17'd0, req_addr[1]}, 32'h0000);
    check("wrap_d0", {28'd0, got_d[0]}, 32'h1);
    check("wrap_d1", {28'd0, got_d[1]}, 32'h2);
    check("wrap_d2", {28'd0, got_d[2]}, 32'h3);
    check("wrap_d3", {28'd0, got_d[3]}, 32'h4);
    check("wrap_pc0", {16'd0, got_pc[0]}, 32'hFFFE);
    check("wrap_pc1", {16'd0, got_pc[1]}, 32'hFFFF);
    check("wrap_pc2", {16'd0, got_pc[2]}, 32'h0000);
    check("wrap_pc3", {16'd0, got_pc[3]}, 32'h0001);

    // Asynchronous reset mid-operation with a read in flight
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (last_req) found = 1;
    end
    check("mid_found_req", {31'd0, found}, 1);
    check("mid_pre_valid", {31'd0, bus.nib_valid}, 1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_async_valid", {31'd0, bus.nib_valid}, 0);
    check("mid_async_req", {31'd0, bus.mem_enable_read}, 0);
    @(posedge clk);
    @(negedge clk);
    release_reset();
    #1;
    check("mid_c0_req", {31'd0, bus.mem_enable_read}, 1);
    check("mid_c0_addr", {17'd0, bus.mem_addr}, 0);
    tick();
    check("mid_c1_valid", {31'd0, bus.nib_valid}, 0);
    for (int i = 0; i < 6; i++) tick();
    check("mid_first_pc", {16'd0, got_pc[0]}, 0);
    check("mid_first_data", {28'd0, got_d[0]}, 32'h3);

    // Randomized traffic against the model
    got_d.delete(); got_pc.delete();
    for (int i = 0; i < 3000; i++) begin
      bus.nib_ready   = ($urandom_range(0, 3) != 0);
      bus.mem_busy    = ($urandom_range(0, 7) == 0);
      bus.redirect    = ($urandom_range(0, 31) == 0);
      bus.redirect_pc = 16'($urandom);
      tick();
    end
    check("rand_progress", {31'd0, got_d.size() > 300}, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
